// File: rtl/kmeans_centroid_update.sv
// Per-cluster sum/count accumulation over an epoch, then sequential restoring division
// to produce new centroids, written back one cluster at a time.
module kmeans_centroid_update #(
    parameter int                 K       = 3,
    parameter int                 DATA_W  = 16,
    parameter int                 CNT_W   = 16,
    parameter logic [DATA_W-1:0]  INIT_X0 = 16'h0200,
    parameter logic [DATA_W-1:0]  INIT_Y0 = 16'h0200,
    parameter logic [DATA_W-1:0]  INIT_X1 = 16'h0600,
    parameter logic [DATA_W-1:0]  INIT_Y1 = 16'h0600,
    parameter logic [DATA_W-1:0]  INIT_X2 = 16'h0180,
    parameter logic [DATA_W-1:0]  INIT_Y2 = 16'h0800,
    parameter logic [DATA_W-1:0]  INIT_X3 = 16'h0000,
    parameter logic [DATA_W-1:0]  INIT_Y3 = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] point_x,
    input  logic [DATA_W-1:0] point_y,
    input  logic [1:0]        point_cluster,
    input  logic              point_valid,
    input  logic              epoch_end,
    output logic              busy,
    output logic              point_lost,
    output logic              cent_wr_valid,
    output logic [1:0]        cent_idx,
    output logic [DATA_W-1:0] cent_x,
    output logic [DATA_W-1:0] cent_y,
    output logic              done
);

    localparam int                SUM_W    = DATA_W + CNT_W;
    localparam int                BIT_W    = $clog2(SUM_W);
    localparam logic [2:0]        K_NUM    = 3'(K);
    localparam logic [1:0]        K_LAST   = 2'(K - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SUM_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_ACCUM,
        S_DIV_X,
        S_DIV_Y,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] init_x(input int i);
        case (i)
            0:       return INIT_X0;
            1:       return INIT_X1;
            2:       return INIT_X2;
            default: return INIT_X3;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] init_y(input int i);
        case (i)
            0:       return INIT_Y0;
            1:       return INIT_Y1;
            2:       return INIT_Y2;
            default: return INIT_Y3;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [SUM_W-1:0]   sum_x_q [4];
    logic [SUM_W-1:0]   sum_x_d [4];
    logic [SUM_W-1:0]   sum_y_q [4];
    logic [SUM_W-1:0]   sum_y_d [4];
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];
    logic [DATA_W-1:0]  ctr_x_q [4];
    logic [DATA_W-1:0]  ctr_x_d [4];
    logic [DATA_W-1:0]  ctr_y_q [4];
    logic [DATA_W-1:0]  ctr_y_d [4];

    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [SUM_W-1:0]   dq_q, dq_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  new_x_q, new_x_d;
    logic [DATA_W-1:0]  new_y_q, new_y_d;

    logic               point_lost_q, point_lost_d;
    logic               cent_wr_valid_q, cent_wr_valid_d;
    logic [1:0]         cent_idx_q, cent_idx_d;
    logic [DATA_W-1:0]  cent_x_q, cent_x_d;
    logic [DATA_W-1:0]  cent_y_q, cent_y_d;
    logic               done_q, done_d;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [CNT_W:0]     trial;
    logic [CNT_W:0]     diff;
    logic               q_bit;
    logic [CNT_W-1:0]   rem_step;
    logic [SUM_W-1:0]   dq_step;

    logic [1:0]         k_nx;
    logic [DATA_W-1:0]  wr_x;
    logic [DATA_W-1:0]  wr_y;

    always_comb begin
        trial    = {rem_q, dq_q[SUM_W-1]};
        diff     = trial - {1'b0, cnt_q[k_q]};
        q_bit    = (trial >= {1'b0, cnt_q[k_q]});
        rem_step = q_bit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        dq_step  = {dq_q[SUM_W-2:0], q_bit};
    end

    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        sum_x_d         = sum_x_q;
        sum_y_d         = sum_y_q;
        cnt_d           = cnt_q;
        ctr_x_d         = ctr_x_q;
        ctr_y_d         = ctr_y_q;
        rem_d           = rem_q;
        dq_d            = dq_q;
        bit_d           = bit_q;
        new_x_d         = new_x_q;
        new_y_d         = new_y_q;
        cent_wr_valid_d = 1'b0;
        cent_idx_d      = cent_idx_q;
        cent_x_d        = cent_x_q;
        cent_y_d        = cent_y_q;
        done_d          = 1'b0;
        point_lost_d    = point_valid && (state_q != S_ACCUM);
        k_nx            = k_q + 2'd1;
        wr_x            = (cnt_q[k_q] != '0) ? new_x_q : ctr_x_q[k_q];
        wr_y            = (cnt_q[k_q] != '0) ? new_y_q : ctr_y_q[k_q];

        case (state_q)
            S_ACCUM: begin
                if (point_valid && ({1'b0, point_cluster} < K_NUM) &&
                    (cnt_q[point_cluster] != CNT_MAX)) begin
                    sum_x_d[point_cluster] = sum_x_q[point_cluster] + SUM_W'(point_x);
                    sum_y_d[point_cluster] = sum_y_q[point_cluster] + SUM_W'(point_y);
                    cnt_d[point_cluster]   = cnt_q[point_cluster] + CNT_W'(1);
                end
                // Divider loads from the _d sums so a same-cycle point is included.
                if (epoch_end) begin
                    k_d = 2'd0;
                    if (cnt_d[0] == '0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DIV_X;
                        dq_d    = sum_x_d[0];
                        rem_d   = '0;
                        bit_d   = '0;
                    end
                end
            end
            S_DIV_X: begin
                rem_d = rem_step;
                dq_d  = dq_step;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_LAST) begin
                    new_x_d = dq_step[DATA_W-1:0];
                    state_d = S_DIV_Y;
                    dq_d    = sum_y_q[k_q];
                    rem_d   = '0;
                    bit_d   = '0;
                end
            end
            S_DIV_Y: begin
                rem_d = rem_step;
                dq_d  = dq_step;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_LAST) begin
                    new_y_d = dq_step[DATA_W-1:0];
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ctr_x_d[k_q]    = wr_x;
                ctr_y_d[k_q]    = wr_y;
                cent_wr_valid_d = 1'b1;
                cent_idx_d      = k_q;
                cent_x_d        = wr_x;
                cent_y_d        = wr_y;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_nx;
                    if (cnt_q[k_nx] == '0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DIV_X;
                        dq_d    = sum_x_q[k_nx];
                        rem_d   = '0;
                        bit_d   = '0;
                    end
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    sum_x_d[i] = '0;
                    sum_y_d[i] = '0;
                    cnt_d[i]   = '0;
                end
                state_d = S_ACCUM;
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_ACCUM;
            k_q             <= '0;
            rem_q           <= '0;
            dq_q            <= '0;
            bit_q           <= '0;
            new_x_q         <= '0;
            new_y_q         <= '0;
            point_lost_q    <= 1'b0;
            cent_wr_valid_q <= 1'b0;
            cent_idx_q      <= '0;
            cent_x_q        <= '0;
            cent_y_q        <= '0;
            done_q          <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
                cnt_q[i]   <= '0;
                ctr_x_q[i] <= init_x(i);
                ctr_y_q[i] <= init_y(i);
            end
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            rem_q           <= rem_d;
            dq_q            <= dq_d;
            bit_q           <= bit_d;
            new_x_q         <= new_x_d;
            new_y_q         <= new_y_d;
            point_lost_q    <= point_lost_d;
            cent_wr_valid_q <= cent_wr_valid_d;
            cent_idx_q      <= cent_idx_d;
            cent_x_q        <= cent_x_d;
            cent_y_q        <= cent_y_d;
            done_q          <= done_d;
            sum_x_q         <= sum_x_d;
            sum_y_q         <= sum_y_d;
            cnt_q           <= cnt_d;
            ctr_x_q         <= ctr_x_d;
            ctr_y_q         <= ctr_y_d;
        end
    end

    assign busy          = (state_q != S_ACCUM);
    assign point_lost    = point_lost_q;
    assign cent_wr_valid = cent_wr_valid_q;
    assign cent_idx      = cent_idx_q;
    assign cent_x        = cent_x_q;
    assign cent_y        = cent_y_q;
    assign done          = done_q;

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Directed bench for kmeans_centroid_update: table of epochs plus hand-written
// sequences for dropped points and reset in the middle of a divide.
module tb_kmeans_centroid_update;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] point_x = '0;
    logic [15:0] point_y = '0;
    logic [1:0]  point_cluster = '0;
    logic        point_valid = 1'b0;
    logic        epoch_end = 1'b0;
    logic        busy;
    logic        point_lost;
    logic        cent_wr_valid;
    logic [1:0]  cent_idx;
    logic [15:0] cent_x;
    logic [15:0] cent_y;
    logic        done;

    kmeans_centroid_update dut (
        .clk           (clk),
        .rst           (rst),
        .point_x       (point_x),
        .point_y       (point_y),
        .point_cluster (point_cluster),
        .point_valid   (point_valid),
        .epoch_end     (epoch_end),
        .busy          (busy),
        .point_lost    (point_lost),
        .cent_wr_valid (cent_wr_valid),
        .cent_idx      (cent_idx),
        .cent_x        (cent_x),
        .cent_y        (cent_y),
        .done          (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_x [3];
    logic [15:0] exp_y [3];
    int          exp_lat;

    typedef struct packed {
        logic [3:0]       n;
        logic [7:0][15:0] px;
        logic [7:0][15:0] py;
        logic [7:0][1:0]  pc;
        logic             last_same;
        logic [2:0][15:0] ex;
        logic [2:0][15:0] ey;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        point_valid = 1'b0;
        epoch_end   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] x, input logic [15:0] y, input logic [1:0] c);
        point_valid   = 1'b1;
        point_x       = x;
        point_y       = y;
        point_cluster = c;
        @(negedge clk);
        point_valid = 1'b0;
        check("no_lost_idle", point_lost, 1'b0);
    endtask

    task automatic set_exp(input logic [15:0] x0, input logic [15:0] y0,
                           input logic [15:0] x1, input logic [15:0] y1,
                           input logic [15:0] x2, input logic [15:0] y2, input int lat);
        exp_x[0] = x0; exp_y[0] = y0;
        exp_x[1] = x1; exp_y[1] = y1;
        exp_x[2] = x2; exp_y[2] = y2;
        exp_lat  = lat;
    endtask

    // Drives epoch_end (optionally with a same-cycle point), then collects the
    // three writes and the done pulse. done is a registered pulse, so it appears
    // exp_lat+2 falling edges after epoch_end is driven.
    task automatic run_epoch(input bit with_pt, input logic [15:0] x, input logic [15:0] y,
                             input logic [1:0] c, input int lost_at);
        int cyc = 0;
        int nw = 0;
        int extra_lost = 0;
        bit got_done = 1'b0;
        epoch_end     = 1'b1;
        point_valid   = with_pt;
        point_x       = x;
        point_y       = y;
        point_cluster = c;
        @(negedge clk);
        epoch_end   = 1'b0;
        point_valid = 1'b0;
        cyc = 1;
        check("busy_after_epoch", busy, 1'b1);
        while (!got_done && cyc < 400) begin
            if (cent_wr_valid) begin
                if (nw < 3) begin
                    check($sformatf("wr%0d_idx", nw), cent_idx, nw);
                    check($sformatf("wr%0d_x", nw), cent_x, exp_x[nw]);
                    check($sformatf("wr%0d_y", nw), cent_y, exp_y[nw]);
                end
                nw++;
            end
            if (lost_at > 0 && cyc == lost_at + 1)
                check("point_lost_pulse", point_lost, 1'b1);
            else if (point_lost)
                extra_lost++;
            if (done) begin
                got_done = 1'b1;
                check("latency", cyc, exp_lat + 2);
            end else begin
                if (lost_at > 0 && cyc == lost_at) begin
                    point_valid   = 1'b1;
                    point_x       = 16'h8000;
                    point_y       = 16'h8000;
                    point_cluster = 2'd0;
                end else begin
                    point_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        point_valid = 1'b0;
        check("done_seen", got_done, 1'b1);
        check("write_count", nw, 3);
        check("extra_lost", extra_lost, 0);
        check("busy_idle", busy, 1'b0);
        check("hold_idx", cent_idx, 2'd2);
        check("hold_x", cent_x, exp_x[2]);
        check("hold_y", cent_y, exp_y[2]);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("wr_quiet", cent_wr_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfeed;
        int lat;
        bit ne;
        bit bad;

        // Two points averaging with truncation: (0x219+0x1E6)/2 = 0x3FF/2 = 0x1FF
        vecs[0] = '0;
        vecs[0].n = 2;
        vecs[0].px[0] = 16'h0219; vecs[0].py[0] = 16'h0219; vecs[0].pc[0] = 2'd0;
        vecs[0].px[1] = 16'h01E6; vecs[0].py[1] = 16'h01E6; vecs[0].pc[1] = 2'd0;
        vecs[0].ex[0] = 16'h01FF; vecs[0].ey[0] = 16'h01FF;
        vecs[0].ex[1] = 16'h0600; vecs[0].ey[1] = 16'h0600;
        vecs[0].ex[2] = 16'h0180; vecs[0].ey[2] = 16'h0800;
        // Three points in cluster 1: sum x 0x1200 / 3 = 0x600
        vecs[1] = '0;
        vecs[1].n = 3;
        vecs[1].px[0] = 16'h0680; vecs[1].py[0] = 16'h0600; vecs[1].pc[0] = 2'd1;
        vecs[1].px[1] = 16'h0600; vecs[1].py[1] = 16'h0600; vecs[1].pc[1] = 2'd1;
        vecs[1].px[2] = 16'h0580; vecs[1].py[2] = 16'h0600; vecs[1].pc[2] = 2'd1;
        vecs[1].ex[0] = 16'h0200; vecs[1].ey[0] = 16'h0200;
        vecs[1].ex[1] = 16'h0600; vecs[1].ey[1] = 16'h0600;
        vecs[1].ex[2] = 16'h0180; vecs[1].ey[2] = 16'h0800;
        // Single point arriving with epoch_end
        vecs[2] = '0;
        vecs[2].n = 1; vecs[2].last_same = 1'b1;
        vecs[2].px[0] = 16'h0100; vecs[2].py[0] = 16'h0800; vecs[2].pc[0] = 2'd2;
        vecs[2].ex[0] = 16'h0200; vecs[2].ey[0] = 16'h0200;
        vecs[2].ex[1] = 16'h0600; vecs[2].ey[1] = 16'h0600;
        vecs[2].ex[2] = 16'h0100; vecs[2].ey[2] = 16'h0800;
        // Out-of-range cluster index is dropped silently
        vecs[3] = '0;
        vecs[3].n = 1;
        vecs[3].px[0] = 16'h1234; vecs[3].py[0] = 16'h1234; vecs[3].pc[0] = 2'd3;
        vecs[3].ex[0] = 16'h0200; vecs[3].ey[0] = 16'h0200;
        vecs[3].ex[1] = 16'h0600; vecs[3].ey[1] = 16'h0600;
        vecs[3].ex[2] = 16'h0180; vecs[3].ey[2] = 16'h0800;
        // All clusters populated; 3/2=1, 50/3=16, 99/3=33, full-scale point
        vecs[4] = '0;
        vecs[4].n = 6; vecs[4].last_same = 1'b1;
        vecs[4].px[0] = 16'h0001; vecs[4].py[0] = 16'h0003; vecs[4].pc[0] = 2'd0;
        vecs[4].px[1] = 16'h0002; vecs[4].py[1] = 16'h0000; vecs[4].pc[1] = 2'd0;
        vecs[4].px[2] = 16'h0010; vecs[4].py[2] = 16'h0020; vecs[4].pc[2] = 2'd1;
        vecs[4].px[3] = 16'h0011; vecs[4].py[3] = 16'h0021; vecs[4].pc[3] = 2'd1;
        vecs[4].px[4] = 16'h0011; vecs[4].py[4] = 16'h0022; vecs[4].pc[4] = 2'd1;
        vecs[4].px[5] = 16'hFFFF; vecs[4].py[5] = 16'hFFFF; vecs[4].pc[5] = 2'd2;
        vecs[4].ex[0] = 16'h0001; vecs[4].ey[0] = 16'h0001;
        vecs[4].ex[1] = 16'h0010; vecs[4].ey[1] = 16'h0021;
        vecs[4].ex[2] = 16'hFFFF; vecs[4].ey[2] = 16'hFFFF;

        do_reset();
        check("reset_outputs",
              {busy, point_lost, cent_wr_valid, cent_idx, cent_x, cent_y, done}, '0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            lat = 0;
            for (int j = 0; j < 3; j++) begin
                ne = 1'b0;
                for (int p = 0; p < int'(vecs[v].n); p++)
                    if (vecs[v].pc[p] == 2'(j)) ne = 1'b1;
                lat += ne ? 65 : 1;
            end
            set_exp(vecs[v].ex[0], vecs[v].ey[0], vecs[v].ex[1], vecs[v].ey[1],
                    vecs[v].ex[2], vecs[v].ey[2], lat);
            nfeed = int'(vecs[v].n) - (vecs[v].last_same ? 1 : 0);
            for (int p = 0; p < nfeed; p++)
                feed(vecs[v].px[p], vecs[v].py[p], vecs[v].pc[p]);
            if (vecs[v].last_same)
                run_epoch(1'b1, vecs[v].px[nfeed], vecs[v].py[nfeed], vecs[v].pc[nfeed], 0);
            else
                run_epoch(1'b0, 16'h0, 16'h0, 2'd0, 0);
        end

        // Point offered during DIV_X is lost and must not reach the next epoch.
        do_reset();
        feed(16'h0400, 16'h0300, 2'd0);
        set_exp(16'h0400, 16'h0300, 16'h0600, 16'h0600, 16'h0180, 16'h0800, 67);
        run_epoch(1'b0, 16'h0, 16'h0, 2'd0, 3);
        set_exp(16'h0400, 16'h0300, 16'h0600, 16'h0600, 16'h0180, 16'h0800, 3);
        run_epoch(1'b0, 16'h0, 16'h0, 2'd0, 0);

        // Reset during DIV_Y of cluster 0 discards sums and learned centroids.
        do_reset();
        feed(16'h0700, 16'h0700, 2'd1);
        feed(16'h0400, 16'h0400, 2'd0);
        epoch_end = 1'b1;
        @(negedge clk);
        epoch_end = 1'b0;
        repeat (39) @(negedge clk);
        check("busy_mid_div_y", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_outputs", {cent_wr_valid, done, cent_x, cent_y}, '0);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cent_wr_valid || done || busy) bad = 1'b1;
        end
        check("quiet_after_rst", bad, 1'b0);
        feed(16'h0300, 16'h0500, 2'd1);
        set_exp(16'h0200, 16'h0200, 16'h0300, 16'h0500, 16'h0180, 16'h0800, 67);
        run_epoch(1'b0, 16'h0, 16'h0, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
